div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide unit: opcode constants and funct3 decode.
package div_unit_pkg;

  localparam int unsigned DIV_XLEN = 32;

  localparam logic [6:0] FUNCT7_M    = 7'b0000001;
  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } div_op_t;

  function automatic div_op_t decode_op(input logic [2:0] funct3);
    div_op_t op;
    op.is_signed = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    op.is_rem    = (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    return op;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake between the execute stage and the divide unit.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DIV_XLEN-1:0] in1;
  logic [DIV_XLEN-1:0] in2;
  logic [2:0]          funct3;
  logic                out_valid;
  logic                out_ready;
  logic [DIV_XLEN-1:0] out;

  modport master (
    output in_valid, in1, in2, funct3, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, funct3, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per cycle,
// special cases (divide by zero, signed overflow) resolved at acceptance.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q, neg_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  div_op_t           op;
  logic              is_ovf;

  // Two's complement negate when n is set; also yields |x| for a signed operand.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic n);
    return n ? XLEN'(~x + XLEN'(1)) : x;
  endfunction

  // One restoring step: shift {rem, quo}, subtract divisor, keep if non-negative.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (!trial[XLEN]) begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign op     = decode_op(bus.funct3);
  assign is_ovf = op.is_signed
               && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.in2 == {XLEN{1'b1}});

  // Next-state and datapath updates; flush overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    is_rem_d    = is_rem_q;
    neg_d       = neg_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            cnt_d    = '0;
            is_rem_d = op.is_rem;
            neg_d    = op.is_signed
                     & (op.is_rem ? bus.in1[XLEN-1] : (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]));
            if (bus.in2 == '0) begin
              out_d   = op.is_rem ? bus.in1 : {XLEN{1'b1}};
              state_d = DONE;
            end else if (is_ovf) begin
              out_d   = op.is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_d = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = cond_neg(bus.in1, op.is_signed & bus.in1[XLEN-1]);
              dvsr_d  = cond_neg(bus.in2, op.is_signed & bus.in2[XLEN-1]);
              state_d = RUN;
            end
          end
        end
        RUN: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(XLEN-1)) begin
            out_d   = cond_neg(is_rem_q ? rem_nx : quo_nx, neg_q);
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      is_rem_q    <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      is_rem_q    <= is_rem_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: arithmetic results, latency, special cases,
// backpressure, flush and reset behaviour.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  div_unit_if bus ();

  div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, measure edges to out_valid, optionally stall, then retire it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in1      = 32'hDEADBEEF;
    bus.in2      = 32'h0BADF00D;
    bus.funct3   = 3'b000;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_out"}, bus.out, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hold_out"}, bus.out, exp);
      check_eq({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_ret_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_ret_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Start an operation and leave it in RUN after the given number of iterations.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int iters);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (iters) @(posedge clk);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_eq({tag, "_no_valid"}, 32'(seen), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.funct3    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset_out", bus.out, 32'h0);
    rst = 1'b0;

    run_op("div_20_3",     FUNCT3_DIV,  32'd20,        32'd3,        32'd6,        33, 0);
    run_op("rem_20_3",     FUNCT3_REM,  32'd20,        32'd3,        32'd2,        33, 0);
    run_op("div_m7_2",     FUNCT3_DIV,  32'hFFFFFFF9,  32'h2,        32'hFFFFFFFD, 33, 0);
    run_op("rem_m7_2",     FUNCT3_REM,  32'hFFFFFFF9,  32'h2,        32'hFFFFFFFF, 33, 0);
    run_op("divu_max_2",   FUNCT3_DIVU, 32'hFFFFFFFF,  32'h2,        32'h7FFFFFFF, 33, 0);
    run_op("remu_max_16",  FUNCT3_REMU, 32'hFFFFFFFF,  32'h10,       32'h0000000F, 33, 0);
    run_op("div_7_m2",     FUNCT3_DIV,  32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
    run_op("div_by0",      FUNCT3_DIV,  32'h1234,      32'h0,        32'hFFFFFFFF, 1,  0);
    run_op("remu_by0",     FUNCT3_REMU, 32'h1234,      32'h0,        32'h00001234, 1,  0);
    run_op("div_ovf",      FUNCT3_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op("rem_ovf",      FUNCT3_REM,  32'h80000000,  32'hFFFFFFFF, 32'h0,        1,  0);
    run_op("divu_min_m1",  FUNCT3_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'h0,        33, 0);
    run_op("bp_div_100_10", FUNCT3_DIV, 32'd100,       32'd10,       32'd10,       33, 10);

    // Flush during the 15th iteration with a competing request presented in the same cycle.
    start_op(FUNCT3_DIV, 32'd20, 32'd3, 14);
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.funct3   = FUNCT3_DIVU;
    bus.in1      = 32'd100;
    bus.in2      = 32'd7;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
    expect_quiet("flush_after", 40);
    run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

    // Reset while an operation is mid-iteration; the prior result (14) must be cleared.
    start_op(FUNCT3_DIV, 32'd20, 32'd3, 10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_run_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_run_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_run_out", bus.out, 32'h0);
    expect_quiet("rst_after", 40);
    run_op("rem_m20_3", FUNCT3_REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
